pattern_capture: RTL and testbench

- Downstream consumer of the timed pattern stimulus (bin/dec/hex signal set).
- Watches the three stimulus buses every clock and detects any change.
- Stamps each change with a free-running cycle count and buffers it in an internal FIFO.
- Hands records to a checker/dump stage over a valid/ready interface, giving the bench a synthesizable, cycle-accurate log of what the stimulus reader actually applied.

---
 rtl/pattern_capture.sv | 121 ++++++++++++
 tb/tb_pattern_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_capture.sv
// Change logger for the bin/dec/hex stimulus buses: every change is timestamped and
// queued in a FWFT FIFO that drains over a valid/ready interface.
module pattern_capture #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [3:0]               bin,
    input  logic [31:0]              dec,
    input  logic [31:0]              hex,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [3:0]               out_bin,
    output logic [31:0]              out_dec,
    output logic [31:0]              out_hex,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned DAT_W = 4 + 32 + 32;
    localparam int unsigned REC_W = TS_W + DAT_W;
    localparam logic [LVL_W-1:0] FullLvl = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] OneLvl  = LVL_W'(1);

    logic [TS_W-1:0]   ts_q;
    logic [DAT_W-1:0]  prev_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [REC_W-1:0]  head_q, head_d;
    logic [REC_W-1:0]  mem [DEPTH];
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [DAT_W-1:0]  cur;
    logic              chg, pop, full, push, drop;

    assign cur     = {bin, dec, hex};
    assign chg     = en && (cur != prev_q);
    assign out_valid = (level_q != '0);
    assign pop     = out_valid && out_ready;
    assign full    = (level_q == FullLvl);
    // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
    assign push    = chg && (!full || pop);
    assign drop    = chg && full && !pop;
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        head_d = head_q;
        // The head register mirrors mem[rd_ptr]; it bypasses memory when the FIFO is
        // (or is becoming) empty so the record is visible one cycle after the change.
        if (push && (level_q == '0 || (pop && level_q == OneLvl))) begin
            head_d = {ts_q, cur};
        end else if (pop && level_q > OneLvl) begin
            head_d = mem[rd_next];
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + OneLvl;
            2'b01:   level_d = level_q - OneLvl;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            prev_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_q + TS_W'(1);
            prev_q     <= cur;
            level_q    <= level_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {ts_q, cur};
    end

    assign out_ts   = head_q[REC_W-1 -: TS_W];
    assign out_bin  = head_q[DAT_W-1 -: 4];
    assign out_dec  = head_q[63:32];
    assign out_hex  = head_q[31:0];
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pattern_capture.sv
// Bench for pattern_capture: a queue-based reference model fills the expected-record
// scoreboard; a negedge monitor compares DUT outputs and counts pops.
module tb_pattern_capture;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TS_W   = 32;
    localparam int unsigned DROP_W = 8;

    typedef struct {
        logic [31:0] ts;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] h;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst_n, en, clr, out_ready;
    logic [3:0]        bin;
    logic [31:0]       dec, hex;
    logic              out_valid, overflow;
    logic [TS_W-1:0]   out_ts;
    logic [3:0]        out_bin;
    logic [31:0]       out_dec, out_hex;
    logic [4:0]        level;
    logic [DROP_W-1:0] drop_cnt;

    pattern_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .bin(bin), .dec(dec), .hex(hex),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_bin(out_bin),
        .out_dec(out_dec), .out_hex(out_hex), .level(level), .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_pops = 0;

    // Reference model state
    rec_t        exp_q[$];
    logic [31:0] m_ts;
    logic [67:0] m_prev;
    logic        m_ovf;
    int          m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sees the same input values the DUT samples at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ts    = 0;
            m_prev  = '0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            rec_t r;
            bit   popped;
            bit   changed;
            popped  = (exp_q.size() != 0) && out_ready;
            changed = en && ({bin, dec, hex} != m_prev);
            if (popped) void'(exp_q.pop_front());
            if (changed) begin
                if (exp_q.size() < DEPTH) begin
                    r.ts = m_ts; r.b = bin; r.d = dec; r.h = hex;
                    exp_q.push_back(r);
                end else if (!clr) begin
                    m_ovf   = 1'b1;
                    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
            end
            if (clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            m_prev = {bin, dec, hex};
            m_ts   = m_ts + 1;
        end
    end

    // Monitor: compares the presented record against the scoreboard head every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("level", 64'(level), 64'(exp_q.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
            if (out_valid && exp_q.size() != 0) begin
                chk("rec_ts", 64'(out_ts), 64'(exp_q[0].ts));
                chk("rec_bin", 64'(out_bin), 64'(exp_q[0].b));
                chk("rec_dec", 64'(out_dec), 64'(exp_q[0].d));
                chk("rec_hex", 64'(out_hex), 64'(exp_q[0].h));
                if (out_ready) n_pops++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; out_ready = 1'b0;
        bin = '0; dec = '0; hex = '0;
        step(2);
        rst_n = 1'b1;                       // now in cycle 0
        step(10);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_level", 64'(level), 64'd0);
        step(10);                           // cycle 20
        bin = 4'b1010; dec = 32'd5; hex = 32'hDEAD_BEEF; out_ready = 1'b1;
        step(1);
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_ts", 64'(out_ts), 64'd20);
        chk("first_bin", 64'(out_bin), 64'hA);
        chk("first_hex", 64'(out_hex), 64'hDEAD_BEEF);
        step(1);
        chk("one_record", 64'(out_valid), 64'd0);

        // Overflow: 20 changes into 16 slots, starting in cycle 22
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hex = 32'h100 + 32'(i);
            step(1);
        end
        chk("full_level", 64'(level), 64'd16);
        chk("full_ovf", 64'(overflow), 64'd1);
        chk("full_drops", 64'(drop_cnt), 64'd4);
        chk("full_head_ts", 64'(out_ts), 64'd22);

        out_ready = 1'b1; hex = 32'h200;
        step(1);
        chk("pushpop_level", 64'(level), 64'd16);
        chk("pushpop_drops", 64'(drop_cnt), 64'd4);
        out_ready = 1'b0; clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drops", 64'(drop_cnt), 64'd0);
        chk("clr_level", 64'(level), 64'd16);

        // Disabled changes are not logged, even after re-enable
        out_ready = 1'b1;
        step(20);
        p0 = n_pops;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dec = dec + 32'd7;
            step(1);
        end
        en = 1'b1;
        step(5);
        chk("en_off_pops", 64'(n_pops - p0), 64'd0);
        bin = 4'b0011;
        step(5);
        chk("en_on_pops", 64'(n_pops - p0), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            clr       = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 1) == 1) bin = 4'($urandom);
            if ($urandom_range(0, 2) == 0) dec = $urandom;
            if ($urandom_range(0, 3) == 0) hex = $urandom;
            step(1);
        end
        clr = 1'b0; en = 1'b1; out_ready = 1'b1;
        step(20);

        // Reset in the middle of a drain
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            dec = dec + 32'd1;
            step(1);
        end
        chk("pre_rst_level", 64'(level), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_ts", 64'(out_ts), 64'd0);
        out_ready = 1'b1;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
